multi_channel_join_fifo: RTL and testbench

MULTI_CHANNEL_JOIN_FIFO -- requirements
Module: multi_channel_join_fifo

---
 rtl/mudkip_fifo_pkg.sv | 14 +
 rtl/join_fifo_lane.sv | 54 +++++
 rtl/multi_channel_join_fifo.sv | 67 ++++++
 tb/tb_multi_channel_join_fifo.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mudkip_fifo_pkg.sv
// Shared helpers for the mudkip FIFO family: occupancy width and lane slicing.
package mudkip_fifo_pkg;

  // Level counter width able to hold 0..depth inclusive.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return int'($clog2(depth)) + 1;
  endfunction

  // Low bit of a lane inside a flat packed bus.
  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/join_fifo_lane.sv
// One channel of the join FIFO: first-word-fall-through storage with an explicit occupancy counter.
module join_fifo_lane
  import mudkip_fifo_pkg::*;
#(
  parameter int unsigned CH_WIDTH = 32,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  logic [CH_WIDTH-1:0]       wr_data,
  output logic [CH_WIDTH-1:0]       rd_data_c,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      full_c,
  output logic                      empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = lvl_w(DEPTH);

  logic [CH_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (!push && pop) level <= level - LW'(1);
    end
  end

  // Storage carries no reset; only the addressed entry is ever written.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_data;
  end

  assign rd_data_c = mem[rd_ptr];
  assign full_c    = (level == LW'(DEPTH));
  assign empty_c   = (level == '0);

endmodule

// File: rtl/multi_channel_join_fifo.sv
// Per-channel FIFOs joined into one wide word: the word is offered only when every channel has data.
module multi_channel_join_fifo
  import mudkip_fifo_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned CH_WIDTH  = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH*CH_WIDTH-1:0]       in_data,
  input  logic [NUM_CH-1:0]                in_valid,
  output logic [NUM_CH-1:0]                in_ready,
  output logic [NUM_CH*CH_WIDTH-1:0]       out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  input  logic                             flush,
  output logic [NUM_CH*lvl_w(DEPTH)-1:0]   level,
  output logic [NUM_CH-1:0]                almost_full,
  output logic                             skew_err,
  input  logic                             clr_err
);

  localparam int unsigned LW = lvl_w(DEPTH);

  logic [NUM_CH-1:0] full_c;
  logic [NUM_CH-1:0] empty_c;
  logic [NUM_CH-1:0] push_c;
  logic              pop_c;
  logic              skew_set_c;

  assign in_ready   = ~full_c;
  assign push_c     = in_valid & in_ready & {NUM_CH{~flush}};
  assign out_valid  = ~(|empty_c);
  assign pop_c      = out_valid && out_ready && !flush;
  // With DEPTH >= 2 no lane is full and empty at once, so any-full && any-empty means two different lanes.
  assign skew_set_c = (|full_c) && (|empty_c);

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_lane
    join_fifo_lane #(
      .CH_WIDTH (CH_WIDTH),
      .DEPTH    (DEPTH)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .push      (push_c[i]),
      .pop       (pop_c),
      .flush     (flush),
      .wr_data   (in_data[lane_lo(i, CH_WIDTH) +: CH_WIDTH]),
      .rd_data_c (out_data[lane_lo(i, CH_WIDTH) +: CH_WIDTH]),
      .level     (level[lane_lo(i, LW) +: LW]),
      .full_c    (full_c[i]),
      .empty_c   (empty_c[i])
    );

    assign almost_full[i] = (level[lane_lo(i, LW) +: LW] >= LW'(AF_THRESH));
  end

  // Sticky misalignment flag; a live set condition wins over clr_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             skew_err <= 1'b0;
    else if (skew_set_c) skew_err <= 1'b1;
    else if (clr_err)    skew_err <= 1'b0;
  end

endmodule

// File: tb/tb_multi_channel_join_fifo.sv
// Directed vector bench for multi_channel_join_fifo (2 lanes x 8 bits, depth 4, almost-full at 3).
module tb_multi_channel_join_fifo;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned CW     = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned AF     = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        flush;
  logic [5:0]  level;
  logic [1:0]  almost_full;
  logic        skew_err;
  logic        clr_err;

  int checks = 0;
  int errors = 0;

  multi_channel_join_fifo #(
    .NUM_CH    (NUM_CH),
    .CH_WIDTH  (CW),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .flush       (flush),
    .level       (level),
    .almost_full (almost_full),
    .skew_err    (skew_err),
    .clr_err     (clr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  iv;
    logic [15:0] d;
    logic        ordy;
    logic        fl;
    logic        clr;
    logic [1:0]  e_rdy;
    logic        e_ov;
    logic [15:0] e_data;
    logic [5:0]  e_lvl;   // octal digits: {ch1, ch0}
    logic [1:0]  e_af;
    logic        e_skew;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [1:0] iv, input logic [15:0] d, input logic ordy,
                             input logic fl, input logic clr, input logic [1:0] e_rdy,
                             input logic e_ov, input logic [15:0] e_data, input logic [5:0] e_lvl,
                             input logic [1:0] e_af, input logic e_skew);
    vec_t r;
    r.iv = iv; r.d = d; r.ordy = ordy; r.fl = fl; r.clr = clr;
    r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_data = e_data; r.e_lvl = e_lvl;
    r.e_af = e_af; r.e_skew = e_skew;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] iv, input logic [15:0] d, input logic ordy,
                       input logic fl, input logic clr);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl; clr_err = clr;
  endtask

  task automatic chk_state(input string tag, input logic [1:0] rdy, input logic ov,
                           input logic [5:0] lvl, input logic [1:0] af, input logic sk);
    chk({tag, " in_ready"}, 32'(in_ready), 32'(rdy));
    chk({tag, " out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, " level"}, 32'(level), 32'(lvl));
    chk({tag, " almost_full"}, 32'(almost_full), 32'(af));
    chk({tag, " skew_err"}, 32'(skew_err), 32'(sk));
  endtask

  initial begin
    // Two-word join with ch1 arriving late, then one pop.
    tbl.push_back(v(2'b01, 16'h0011, 1, 0, 0, 2'b11, 0, 16'h0000, 6'o00, 2'b00, 0));
    tbl.push_back(v(2'b00, 16'h0000, 1, 0, 0, 2'b11, 0, 16'h0000, 6'o01, 2'b00, 0));
    tbl.push_back(v(2'b00, 16'h0000, 1, 0, 0, 2'b11, 0, 16'h0000, 6'o01, 2'b00, 0));
    tbl.push_back(v(2'b10, 16'h2200, 1, 0, 0, 2'b11, 0, 16'h0000, 6'o01, 2'b00, 0));
    tbl.push_back(v(2'b00, 16'h0000, 1, 0, 0, 2'b11, 1, 16'h2211, 6'o11, 2'b00, 0));
    tbl.push_back(v(2'b00, 16'h0000, 0, 0, 0, 2'b11, 0, 16'h0000, 6'o00, 2'b00, 0));
    // Fill both lanes with out_ready low; fifth write refused; then drain in order.
    tbl.push_back(v(2'b11, 16'hB0A0, 0, 0, 0, 2'b11, 0, 16'h0000, 6'o00, 2'b00, 0));
    tbl.push_back(v(2'b11, 16'hB1A1, 0, 0, 0, 2'b11, 1, 16'hB0A0, 6'o11, 2'b00, 0));
    tbl.push_back(v(2'b11, 16'hB2A2, 0, 0, 0, 2'b11, 1, 16'hB0A0, 6'o22, 2'b00, 0));
    tbl.push_back(v(2'b11, 16'hB3A3, 0, 0, 0, 2'b11, 1, 16'hB0A0, 6'o33, 2'b11, 0));
    tbl.push_back(v(2'b11, 16'hB4A4, 0, 0, 0, 2'b00, 1, 16'hB0A0, 6'o44, 2'b11, 0));
    tbl.push_back(v(2'b00, 16'h0000, 1, 0, 0, 2'b00, 1, 16'hB0A0, 6'o44, 2'b11, 0));
    tbl.push_back(v(2'b00, 16'h0000, 1, 0, 0, 2'b11, 1, 16'hB1A1, 6'o33, 2'b11, 0));
    tbl.push_back(v(2'b00, 16'h0000, 1, 0, 0, 2'b11, 1, 16'hB2A2, 6'o22, 2'b00, 0));
    tbl.push_back(v(2'b00, 16'h0000, 1, 0, 0, 2'b11, 1, 16'hB3A3, 6'o11, 2'b00, 0));
    tbl.push_back(v(2'b00, 16'h0000, 0, 0, 0, 2'b11, 0, 16'h0000, 6'o00, 2'b00, 0));
    // Push and pop together at level 1.
    tbl.push_back(v(2'b11, 16'h2010, 0, 0, 0, 2'b11, 0, 16'h0000, 6'o00, 2'b00, 0));
    tbl.push_back(v(2'b11, 16'h2111, 1, 0, 0, 2'b11, 1, 16'h2010, 6'o11, 2'b00, 0));
    tbl.push_back(v(2'b00, 16'h0000, 0, 0, 0, 2'b11, 1, 16'h2111, 6'o11, 2'b00, 0));
    tbl.push_back(v(2'b00, 16'h0000, 1, 0, 0, 2'b11, 1, 16'h2111, 6'o11, 2'b00, 0));
    // ch0 alone fills up -> skew_err; flush keeps it; clr_err clears it.
    tbl.push_back(v(2'b01, 16'h0001, 0, 0, 0, 2'b11, 0, 16'h0000, 6'o00, 2'b00, 0));
    tbl.push_back(v(2'b01, 16'h0002, 0, 0, 0, 2'b11, 0, 16'h0000, 6'o01, 2'b00, 0));
    tbl.push_back(v(2'b01, 16'h0003, 0, 0, 0, 2'b11, 0, 16'h0000, 6'o02, 2'b00, 0));
    tbl.push_back(v(2'b01, 16'h0004, 0, 0, 0, 2'b11, 0, 16'h0000, 6'o03, 2'b01, 0));
    tbl.push_back(v(2'b00, 16'h0000, 0, 0, 0, 2'b10, 0, 16'h0000, 6'o04, 2'b01, 0));
    tbl.push_back(v(2'b10, 16'h5500, 0, 0, 0, 2'b10, 0, 16'h0000, 6'o04, 2'b01, 1));
    tbl.push_back(v(2'b00, 16'h0000, 0, 0, 0, 2'b10, 1, 16'h5501, 6'o14, 2'b01, 1));
    tbl.push_back(v(2'b00, 16'h0000, 0, 1, 0, 2'b10, 1, 16'h5501, 6'o14, 2'b01, 1));
    tbl.push_back(v(2'b00, 16'h0000, 0, 0, 1, 2'b11, 0, 16'h0000, 6'o00, 2'b00, 1));
    // Levels 3/2 then flush with pushes and out_ready high.
    tbl.push_back(v(2'b11, 16'h3130, 0, 0, 0, 2'b11, 0, 16'h0000, 6'o00, 2'b00, 0));
    tbl.push_back(v(2'b11, 16'h3232, 0, 0, 0, 2'b11, 1, 16'h3130, 6'o11, 2'b00, 0));
    tbl.push_back(v(2'b01, 16'h0033, 0, 0, 0, 2'b11, 1, 16'h3130, 6'o22, 2'b00, 0));
    tbl.push_back(v(2'b11, 16'h4444, 1, 1, 0, 2'b11, 1, 16'h3130, 6'o23, 2'b01, 0));
    tbl.push_back(v(2'b00, 16'h0000, 0, 0, 0, 2'b11, 0, 16'h0000, 6'o00, 2'b00, 0));
    tbl.push_back(v(2'b11, 16'h5150, 0, 0, 0, 2'b11, 0, 16'h0000, 6'o00, 2'b00, 0));
    tbl.push_back(v(2'b00, 16'h0000, 0, 0, 0, 2'b11, 1, 16'h5150, 6'o11, 2'b00, 0));

    drive(2'b00, 16'h0000, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl, tbl[i].clr);
      #1;
      chk_state($sformatf("v%0d", i), tbl[i].e_rdy, tbl[i].e_ov, tbl[i].e_lvl,
                tbl[i].e_af, tbl[i].e_skew);
      if (tbl[i].e_ov) chk($sformatf("v%0d out_data", i), 32'(out_data), 32'(tbl[i].e_data));
    end

    // Build up skew_err and a burst, then reset asynchronously between edges.
    @(negedge clk); drive(2'b00, 16'h0000, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drive(2'b01, 16'(8'h70 + k), 0, 0, 0);
    end
    @(negedge clk); drive(2'b00, 16'h0000, 0, 0, 0);
    @(negedge clk); drive(2'b10, 16'h7700, 0, 0, 0);
    #1;
    chk_state("pre_rst", 2'b10, 0, 6'o04, 2'b01, 1);
    #2 rst = 1'b1;
    #1;
    chk_state("async_rst", 2'b11, 0, 6'o00, 2'b00, 0);
    @(negedge clk);
    drive(2'b00, 16'h0000, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Fresh sequence written from the first edge after release, then drained in order.
    for (int k = 0; k < 3; k++) begin
      drive(2'b11, {8'(8'h61 + 2*k), 8'(8'h60 + 2*k)}, 0, 0, 0);
      @(negedge clk);
    end
    drive(2'b00, 16'h0000, 0, 0, 0);
    #1;
    chk_state("post_rst_fill", 2'b11, 1, 6'o33, 2'b11, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      chk($sformatf("drain%0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("drain%0d out_data", k), 32'(out_data),
          32'({8'(8'h61 + 2*k), 8'(8'h60 + 2*k)}));
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk_state("drained", 2'b11, 0, 6'o00, 2'b00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
